axi_apb_bridge: RTL and testbench

AXI4-Lite slave to APB master bridge. Sits directly upstream of the APB register interface in AXI_SPI_IF: it converts single AXI4-Lite read/write transactions into APB SETUP/ACCESS transfers and returns the completion as B/R responses. It carries one transaction at a time, with a programmable PREADY timeout.

---
 rtl/axi_apb_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_apb_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_apb_bridge
// Function : AXI4-Lite slave to APB master, one transaction in flight, with a
//            PREADY timeout that aborts with DECERR.
// Revision : 1.0
// ============================================================================
module axi_apb_bridge #(
    parameter int g_apb_addr_width = 32,
    parameter int g_apb_data_width = 32,
    parameter int g_timeout_cycles = 16
) (
    input  logic                            pclk_i,
    input  logic                            preset_i,
    input  logic [g_apb_addr_width-1:0]     awaddr_i,
    input  logic                            awvalid_i,
    output logic                            awready_o,
    input  logic [g_apb_data_width-1:0]     wdata_i,
    input  logic [g_apb_data_width/8-1:0]   wstrb_i,
    input  logic                            wvalid_i,
    output logic                            wready_o,
    output logic [1:0]                      bresp_o,
    output logic                            bvalid_o,
    input  logic                            bready_i,
    input  logic [g_apb_addr_width-1:0]     araddr_i,
    input  logic                            arvalid_i,
    output logic                            arready_o,
    output logic [g_apb_data_width-1:0]     rdata_o,
    output logic [1:0]                      rresp_o,
    output logic                            rvalid_o,
    input  logic                            rready_i,
    output logic [g_apb_addr_width-1:0]     paddr_o,
    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [g_apb_data_width-1:0]     pwdata_o,
    output logic [g_apb_data_width/8-1:0]   pstrb_o,
    input  logic                            pready_i,
    input  logic [g_apb_data_width-1:0]     prdata_i,
    input  logic                            pslverr_i
);

    localparam int c_strb_w = g_apb_data_width / 8;
    localparam int c_cnt_w  = (g_timeout_cycles > 0) ? $clog2(g_timeout_cycles + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(g_timeout_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_WRESP  = 3'd3,
        S_RRESP  = 3'd4
    } state_t;

    state_t                      r_state, w_state;
    logic                        r_lww, w_lww;
    logic [c_cnt_w-1:0]          r_cnt, w_cnt;
    logic                        r_wack, w_wack;
    logic                        r_arack, w_arack;
    logic [g_apb_addr_width-1:0] r_paddr, w_paddr;
    logic                        r_psel, w_psel;
    logic                        r_penable, w_penable;
    logic                        r_pwrite, w_pwrite;
    logic [g_apb_data_width-1:0] r_pwdata, w_pwdata;
    logic [c_strb_w-1:0]         r_pstrb, w_pstrb;
    logic [1:0]                  r_bresp, w_bresp;
    logic                        r_bvalid, w_bvalid;
    logic [g_apb_data_width-1:0] r_rdata, w_rdata;
    logic [1:0]                  r_rresp, w_rresp;
    logic                        r_rvalid, w_rvalid;
    logic                        w_wr_pend;
    logic                        w_rd_pend;
    logic                        w_done;
    logic [1:0]                  w_resp;
    logic [g_apb_data_width-1:0] w_rd_val;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            r_state   <= S_IDLE;
            r_lww     <= 1'b0;
            r_cnt     <= '0;
            r_wack    <= 1'b0;
            r_arack   <= 1'b0;
            r_paddr   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_bresp   <= 2'b00;
            r_bvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_rvalid  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_lww     <= w_lww;
            r_cnt     <= w_cnt;
            r_wack    <= w_wack;
            r_arack   <= w_arack;
            r_paddr   <= w_paddr;
            r_psel    <= w_psel;
            r_penable <= w_penable;
            r_pwrite  <= w_pwrite;
            r_pwdata  <= w_pwdata;
            r_pstrb   <= w_pstrb;
            r_bresp   <= w_bresp;
            r_bvalid  <= w_bvalid;
            r_rdata   <= w_rdata;
            r_rresp   <= w_rresp;
            r_rvalid  <= w_rvalid;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_lww     = r_lww;
        w_cnt     = r_cnt;
        w_wack    = 1'b0;
        w_arack   = 1'b0;
        w_paddr   = r_paddr;
        w_psel    = r_psel;
        w_penable = r_penable;
        w_pwrite  = r_pwrite;
        w_pwdata  = r_pwdata;
        w_pstrb   = r_pstrb;
        w_bresp   = r_bresp;
        w_bvalid  = r_bvalid;
        w_rdata   = r_rdata;
        w_rresp   = r_rresp;
        w_rvalid  = r_rvalid;
        w_wr_pend = awvalid_i & wvalid_i;
        w_rd_pend = arvalid_i;
        w_done    = 1'b0;
        w_resp    = 2'b00;
        w_rd_val  = '0;

        case (r_state)
            S_IDLE: begin
                // Ready pulses are registered, so the handshake completes in
                // the cycle after the request is first seen.
                if (r_wack) begin
                    w_paddr  = awaddr_i;
                    w_pwrite = 1'b1;
                    w_pwdata = wdata_i;
                    w_pstrb  = wstrb_i;
                    w_psel   = 1'b1;
                    w_state  = S_SETUP;
                end else if (r_arack) begin
                    w_paddr  = araddr_i;
                    w_pwrite = 1'b0;
                    w_pwdata = '0;
                    w_pstrb  = '0;
                    w_psel   = 1'b1;
                    w_state  = S_SETUP;
                end else if (w_wr_pend && w_rd_pend) begin
                    // Only a genuine tie moves the fairness flag.
                    w_wack  = ~r_lww;
                    w_arack = r_lww;
                    w_lww   = ~r_lww;
                end else begin
                    w_wack  = w_wr_pend;
                    w_arack = w_rd_pend;
                end
            end
            S_SETUP: begin
                w_penable = 1'b1;
                w_cnt     = '0;
                w_state   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready_i) begin
                    w_done   = 1'b1;
                    w_resp   = pslverr_i ? 2'b10 : 2'b00;
                    w_rd_val = prdata_i;
                end else if ((g_timeout_cycles != 0) && (r_cnt == c_cnt_last)) begin
                    w_done   = 1'b1;
                    w_resp   = 2'b11;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
                if (w_done) begin
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_paddr   = '0;
                    w_pwrite  = 1'b0;
                    w_pwdata  = '0;
                    w_pstrb   = '0;
                    if (r_pwrite) begin
                        w_bvalid = 1'b1;
                        w_bresp  = w_resp;
                        w_state  = S_WRESP;
                    end else begin
                        w_rvalid = 1'b1;
                        w_rresp  = w_resp;
                        w_rdata  = w_rd_val;
                        w_state  = S_RRESP;
                    end
                end
            end
            S_WRESP: begin
                if (bready_i) begin
                    w_bvalid = 1'b0;
                    w_bresp  = 2'b00;
                    w_state  = S_IDLE;
                end
            end
            S_RRESP: begin
                if (rready_i) begin
                    w_rvalid = 1'b0;
                    w_rresp  = 2'b00;
                    w_rdata  = '0;
                    w_state  = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign awready_o = r_wack;
    assign wready_o  = r_wack;
    assign arready_o = r_arack;
    assign paddr_o   = r_paddr;
    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign pwrite_o  = r_pwrite;
    assign pwdata_o  = r_pwdata;
    assign pstrb_o   = r_pstrb;
    assign bresp_o   = r_bresp;
    assign bvalid_o  = r_bvalid;
    assign rdata_o   = r_rdata;
    assign rresp_o   = r_rresp;
    assign rvalid_o  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_axi_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_apb_bridge
// Function : Directed and randomized checks of axi_apb_bridge against a
//            transaction-level model with a word-array APB slave.
// Revision : 1.0
// ============================================================================
module tb_axi_apb_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    logic [31:0] sl_mem  [16];
    logic [31:0] exp_mem [16];
    int          acc_cnt;
    int          cfg_wait = 0;
    bit          cfg_err  = 1'b0;
    bit          model_lww;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi_apb_bridge #(
        .g_apb_addr_width (32),
        .g_apb_data_width (32),
        .g_timeout_cycles (TO)
    ) dut (
        .pclk_i    (clk),
        .preset_i  (rst),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .paddr_o   (paddr),
        .psel_o    (psel),
        .penable_o (penable),
        .pwrite_o  (pwrite),
        .pwdata_o  (pwdata),
        .pstrb_o   (pstrb),
        .pready_i  (pready),
        .prdata_i  (prdata),
        .pslverr_i (pslverr)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    // APB slave: cfg_wait ACCESS cycles of PREADY low, then ready with optional error.
    assign pready  = penable && (acc_cnt >= cfg_wait);
    assign pslverr = pready && cfg_err;
    assign prdata  = sl_mem[paddr[5:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= 0;
            for (int i = 0; i < 16; i++) sl_mem[i] <= init_word(i);
        end else begin
            if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
            else                            acc_cnt <= 0;
            if (psel && penable && pready && pwrite && !pslverr)
                for (int b = 0; b < 4; b++)
                    if (pstrb[b]) sl_mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_lww = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    endtask

    // Arbitration rule: ties alternate starting with the write; non-ties keep the flag.
    task automatic model_pick(input bit wr, input bit rd, output bit pick_wr);
        if (wr && rd) begin
            pick_wr   = !model_lww;
            model_lww = pick_wr;
        end else begin
            pick_wr = wr;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Carry one already-requested transaction through handshake, APB and response.
    task automatic serve(input bit exp_wr, input int waits, input bit err,
                         input int bhold, input bit rearm);
        int          n, acc, eacc, idx;
        bit          tmo;
        logic [31:0] a, d, erdata;
        logic [3:0]  s;
        logic [1:0]  eresp;
        a      = exp_wr ? awaddr : araddr;
        d      = exp_wr ? wdata : 32'h0;
        s      = exp_wr ? wstrb : 4'h0;
        idx    = int'(a[5:2]);
        tmo    = (waits >= TO);
        eacc   = tmo ? TO : waits + 1;
        eresp  = tmo ? 2'b11 : (err ? 2'b10 : 2'b00);
        erdata = (exp_wr || tmo) ? 32'h0 : exp_mem[idx];
        cfg_wait = waits;
        cfg_err  = err;

        n = 0;
        while (awready !== 1'b1 && arready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("handshake_bound", 64'(n < 20), 64'd1);
        check("awready", awready, exp_wr);
        check("wready", wready, exp_wr);
        check("arready", arready, !exp_wr);
        @(posedge clk); #1;
        if (exp_wr) begin awvalid = 1'b0; wvalid = 1'b0; end
        else arvalid = 1'b0;

        check("setup_psel", psel, 1'b1);
        check("setup_penable", penable, 1'b0);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", pwrite, exp_wr);
        check("setup_pstrb", pstrb, s);
        check("setup_pwdata", pwdata, d);
        check("setup_no_ready", {awready, wready, arready}, 3'b000);

        acc = 0;
        @(posedge clk); #1;
        while (penable === 1'b1 && acc < 200) begin
            acc++;
            check("access_psel", psel, 1'b1);
            check("access_pwdata", pwdata, d);
            check("access_pstrb", pstrb, s);
            @(posedge clk); #1;
        end
        check("access_cycles", 64'(acc), 64'(eacc));
        check("psel_drop", {psel, penable}, 2'b00);

        for (int h = 0; h <= bhold; h++) begin
            if (h == 0 && rearm) begin
                awaddr = nxt_addr; wdata = nxt_data; wstrb = 4'hF;
                awvalid = 1'b1; wvalid = 1'b1;
            end
            if (exp_wr) begin
                check("bvalid", bvalid, 1'b1);
                check("bresp", bresp, eresp);
            end else begin
                check("rvalid", rvalid, 1'b1);
                check("rresp", rresp, eresp);
                check("rdata", rdata, erdata);
            end
            check("resp_no_ready", {awready, wready, arready}, 3'b000);
            if (h == bhold) begin
                if (exp_wr) bready = 1'b1;
                else        rready = 1'b1;
            end
            @(posedge clk); #1;
        end
        bready = 1'b0;
        rready = 1'b0;
        check("valid_drop", {bvalid, rvalid}, 2'b00);
        check("resp_clear", {bresp, rresp, rdata}, 36'h0);

        if (exp_wr && !tmo && !err)
            for (int b = 0; b < 4; b++)
                if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic req_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    endtask

    task automatic req_rd(input logic [31:0] a);
        araddr = a; arvalid = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pw;
        int r, waits, idx;

        do_reset();
        check("rst_handshake", {awready, wready, arready}, 3'b000);
        check("rst_apb_ctrl", {psel, penable, pwrite}, 3'b000);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", {pwdata, pstrb}, 36'h0);
        check("rst_resp", {bvalid, rvalid, bresp, rresp}, 6'h0);
        check("rst_rdata", rdata, 32'h0);

        // Zero-wait write: response in the third cycle after the handshake.
        req_wr(32'h10, 32'hA5A5_A5A5, 4'hF);
        model_pick(1'b1, 1'b0, pw);
        serve(pw, 0, 1'b0, 0, 1'b0);

        // Read with three low-PREADY ACCESS cycles.
        req_wr(32'h04, 32'h1234_5678, 4'hF);
        model_pick(1'b1, 1'b0, pw);
        serve(pw, 0, 1'b0, 0, 1'b0);
        req_rd(32'h04);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, 3, 1'b0, 0, 1'b0);
        req_rd(32'h10);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, 0, 1'b0, 0, 1'b0);

        // Slave error on a write must not update memory; partial strobe write.
        req_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        model_pick(1'b1, 1'b0, pw);
        serve(pw, 1, 1'b1, 0, 1'b0);
        req_wr(32'h10, 32'h0BAD_F00D, 4'h5);
        model_pick(1'b1, 1'b0, pw);
        serve(pw, 2, 1'b0, 1, 1'b0);
        req_rd(32'h10);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, 0, 1'b1, 0, 1'b0);

        // Timeout boundary: ready on the last allowed cycle, then stuck low.
        req_rd(32'h04);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, TO - 1, 1'b0, 0, 1'b0);
        req_rd(32'h04);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, 1000, 1'b0, 0, 1'b0);
        req_wr(32'h18, 32'h5555_AAAA, 4'hF);
        model_pick(1'b1, 1'b0, pw);
        serve(pw, 1000, 1'b0, 0, 1'b0);
        req_rd(32'h18);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, 0, 1'b0, 0, 1'b0);

        // Simultaneous read and write requests, twice.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            req_wr(32'h20 + 32'(k), 32'h0F0F_0000 + 32'(k), 4'hF);
            req_rd(32'h24);
            model_pick(1'b1, 1'b1, pw);
            check("tie_choice", pw, (k == 0) ? 1'b1 : 1'b0);
            serve(pw, 0, 1'b0, 0, 1'b0);
            model_pick(!pw, pw, pw);
            serve(pw, 0, 1'b0, 0, 1'b0);
        end

        // Backpressured write response with a second write waiting behind it.
        nxt_addr = 32'h0C;
        nxt_data = 32'h7777_1111;
        req_wr(32'h08, 32'h3333_4444, 4'hF);
        model_pick(1'b1, 1'b0, pw);
        serve(pw, 0, 1'b0, 5, 1'b1);
        model_pick(1'b1, 1'b0, pw);
        serve(pw, 0, 1'b0, 0, 1'b0);
        req_rd(32'h0C);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, 0, 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of ACCESS drops the write.
        cfg_wait = 1000;
        req_wr(32'h30, 32'h9999_9999, 4'hF);
        r = 0;
        while (penable !== 1'b1 && r < 20) begin
            @(posedge clk); #1; r++;
        end
        check("reset_reach_access", penable, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_apb", {psel, penable}, 2'b00);
        check("reset_async_resp", {bvalid, rvalid}, 2'b00);
        check("reset_async_ready", {awready, wready, arready}, 3'b000);
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        req_rd(32'h30);
        model_pick(1'b0, 1'b1, pw);
        serve(pw, 0, 1'b0, 0, 1'b0);

        // Randomized single transactions.
        for (int t = 0; t < 40; t++) begin
            idx = int'($urandom_range(15, 0));
            r   = int'($urandom_range(9, 0));
            waits = (r < 7) ? (r % 4) : ((r == 9) ? 30 : r);
            if ($urandom_range(1, 0) == 1)
                req_wr(32'(idx * 4), $urandom, 4'($urandom_range(15, 0)));
            else
                req_rd(32'(idx * 4));
            model_pick(awvalid && wvalid, arvalid, pw);
            serve(pw, waits, ($urandom_range(7, 0) == 0), int'($urandom_range(2, 0)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
